// File: rtl/axi_slv_rd.sv
// axi_slv_rd - AXI read-side slave responder.
//
// Accepts AR requests into an in-order FIFO and answers each with a burst of
// R beats. Beat data is the beat byte address zero-extended, so a master can
// check reassembly without a backing memory. FIXED, INCR and WRAP addressing
// are supported. Per-beat responses: SLVERR for a malformed WRAP (bad length
// or unaligned start) or a reserved burst type, DECERR at or above ADDR_LIMIT,
// otherwise OKAY.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   axi_slv_ar*              AR channel (id, addr, len, size, burst, user,
//                            valid in; ready out)
//   axi_slv_r*               R channel (id, data, resp, user, last, valid
//                            out; ready in)
module axi_slv_rd #(
    parameter int unsigned AXI_ID_WIDTH    = 4,
    parameter int unsigned AXI_ADDR_WIDTH  = 32,
    parameter int unsigned AXI_DATA_WIDTH  = 64,
    parameter int unsigned AXI_LEN_WIDTH   = 8,
    parameter int unsigned AXI_SIZE_WIDTH  = 3,
    parameter int unsigned AXI_BURST_WIDTH = 2,
    parameter int unsigned AXI_RESP_WIDTH  = 2,
    parameter int unsigned AXI_USER_WIDTH  = 4,
    parameter int unsigned AR_DEPTH        = 4,
    parameter int unsigned RD_LATENCY      = 2,
    parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = 'h1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXI_ID_WIDTH-1:0]    axi_slv_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]  axi_slv_araddr,
    input  logic [AXI_LEN_WIDTH-1:0]   axi_slv_arlen,
    input  logic [AXI_SIZE_WIDTH-1:0]  axi_slv_arsize,
    input  logic [AXI_BURST_WIDTH-1:0] axi_slv_arburst,
    input  logic [AXI_USER_WIDTH-1:0]  axi_slv_aruser,
    input  logic                       axi_slv_arvalid,
    output logic                       axi_slv_arready,
    output logic [AXI_ID_WIDTH-1:0]    axi_slv_rid,
    output logic [AXI_DATA_WIDTH-1:0]  axi_slv_rdata,
    output logic [AXI_RESP_WIDTH-1:0]  axi_slv_rresp,
    output logic [AXI_USER_WIDTH-1:0]  axi_slv_ruser,
    output logic                       axi_slv_rlast,
    output logic                       axi_slv_rvalid,
    input  logic                       axi_slv_rready
);

    localparam logic [AXI_BURST_WIDTH-1:0] BURST_FIXED = AXI_BURST_WIDTH'(0);
    localparam logic [AXI_BURST_WIDTH-1:0] BURST_WRAP  = AXI_BURST_WIDTH'(2);
    localparam logic [AXI_BURST_WIDTH-1:0] BURST_RSVD  = AXI_BURST_WIDTH'(3);

    localparam logic [AXI_RESP_WIDTH-1:0] RESP_OKAY   = AXI_RESP_WIDTH'(0);
    localparam logic [AXI_RESP_WIDTH-1:0] RESP_SLVERR = AXI_RESP_WIDTH'(2);
    localparam logic [AXI_RESP_WIDTH-1:0] RESP_DECERR = AXI_RESP_WIDTH'(3);

    localparam int unsigned PTR_W = (AR_DEPTH > 1) ? $clog2(AR_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(AR_DEPTH + 1);
    localparam int unsigned LAT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } state_t;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]    id;
        logic [AXI_ADDR_WIDTH-1:0]  addr;
        logic [AXI_LEN_WIDTH-1:0]   len;
        logic [AXI_SIZE_WIDTH-1:0]  size;
        logic [AXI_BURST_WIDTH-1:0] burst;
        logic [AXI_USER_WIDTH-1:0]  user;
    } ar_req_t;

    // ------------------------------------------------------------------
    // AR request FIFO
    // ------------------------------------------------------------------
    ar_req_t          fifo_mem [AR_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    ar_req_t          ar_in;
    ar_req_t          head;

    state_t           state;

    assign ar_in = '{id:    axi_slv_arid,
                     addr:  axi_slv_araddr,
                     len:   axi_slv_arlen,
                     size:  axi_slv_arsize,
                     burst: axi_slv_arburst,
                     user:  axi_slv_aruser};

    assign fifo_full       = (fifo_cnt == CNT_W'(AR_DEPTH));
    assign fifo_empty      = (fifo_cnt == '0);
    assign axi_slv_arready = ~fifo_full;
    assign push            = axi_slv_arvalid & ~fifo_full;
    assign pop             = (state == ST_IDLE) & ~fifo_empty;
    assign head            = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ar_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Burst legality of the FIFO head, latched at pop so the whole burst
    // carries one error flag.
    // ------------------------------------------------------------------
    logic [AXI_ADDR_WIDTH-1:0] head_bytes_m1;
    logic                      head_len_ok;
    logic                      head_err;

    always_comb begin
        head_bytes_m1 = (AXI_ADDR_WIDTH'(1) << head.size) - 1'b1;
        head_len_ok   = (head.len == AXI_LEN_WIDTH'(1))  ||
                        (head.len == AXI_LEN_WIDTH'(3))  ||
                        (head.len == AXI_LEN_WIDTH'(7))  ||
                        (head.len == AXI_LEN_WIDTH'(15));
        head_err      = 1'b0;
        if (head.burst == BURST_WRAP) begin
            head_err = !head_len_ok || ((head.addr & head_bytes_m1) != '0);
        end else if (head.burst == BURST_RSVD) begin
            head_err = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Active burst state and next-beat address
    // ------------------------------------------------------------------
    logic [AXI_ADDR_WIDTH-1:0]  cur_addr;
    logic [AXI_LEN_WIDTH-1:0]   cur_len;
    logic [AXI_SIZE_WIDTH-1:0]  cur_size;
    logic [AXI_BURST_WIDTH-1:0] cur_burst;
    logic                       cur_err;
    logic [AXI_LEN_WIDTH-1:0]   beat_cnt;
    logic [LAT_W-1:0]           lat_cnt;

    logic [AXI_ADDR_WIDTH-1:0]  bytes;
    logic [AXI_ADDR_WIDTH-1:0]  total_m1;
    logic [AXI_ADDR_WIDTH-1:0]  next_addr;

    always_comb begin
        bytes    = AXI_ADDR_WIDTH'(1) << cur_size;
        total_m1 = ((AXI_ADDR_WIDTH'(cur_len) + 1'b1) << cur_size) - 1'b1;
        if (cur_burst == BURST_FIXED) begin
            next_addr = cur_addr;
        end else if (cur_burst == BURST_WRAP) begin
            next_addr = (cur_addr & ~total_m1) | ((cur_addr + bytes) & total_m1);
        end else begin
            // INCR and the reserved encoding: align down, then step.
            next_addr = (cur_addr & ~(bytes - 1'b1)) + bytes;
        end
    end

    function automatic logic [AXI_RESP_WIDTH-1:0] beat_resp(
        input logic                      err,
        input logic [AXI_ADDR_WIDTH-1:0] addr
    );
        if (err) begin
            return RESP_SLVERR;
        end else if (addr >= ADDR_LIMIT) begin
            return RESP_DECERR;
        end else begin
            return RESP_OKAY;
        end
    endfunction

    // ------------------------------------------------------------------
    // Response FSM; all R outputs are registered here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            lat_cnt        <= '0;
            beat_cnt       <= '0;
            cur_addr       <= '0;
            cur_len        <= '0;
            cur_size       <= '0;
            cur_burst      <= '0;
            cur_err        <= 1'b0;
            axi_slv_rid    <= '0;
            axi_slv_rdata  <= '0;
            axi_slv_rresp  <= '0;
            axi_slv_ruser  <= '0;
            axi_slv_rlast  <= 1'b0;
            axi_slv_rvalid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        cur_addr      <= head.addr;
                        cur_len       <= head.len;
                        cur_size      <= head.size;
                        cur_burst     <= head.burst;
                        cur_err       <= head_err;
                        axi_slv_rid   <= head.id;
                        axi_slv_ruser <= head.user;
                        beat_cnt      <= '0;
                        lat_cnt       <= LAT_W'(RD_LATENCY);
                        state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt == '0) begin
                        axi_slv_rvalid <= 1'b1;
                        axi_slv_rdata  <= AXI_DATA_WIDTH'(cur_addr);
                        axi_slv_rresp  <= beat_resp(cur_err, cur_addr);
                        axi_slv_rlast  <= (cur_len == '0);
                        state          <= ST_BURST;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                ST_BURST: begin
                    if (axi_slv_rready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        // rlast is the registered (beat_cnt == len) flag.
                        if (axi_slv_rlast) begin
                            axi_slv_rvalid <= 1'b0;
                            axi_slv_rlast  <= 1'b0;
                            state          <= ST_IDLE;
                        end else begin
                            cur_addr      <= next_addr;
                            axi_slv_rdata <= AXI_DATA_WIDTH'(next_addr);
                            axi_slv_rresp <= beat_resp(cur_err, next_addr);
                            axi_slv_rlast <= ((beat_cnt + 1'b1) == cur_len);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slv_rd.sv
// Directed testbench for axi_slv_rd with hand-computed expected beats.
module tb_axi_slv_rd;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [3:0]  aruser;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  ruser;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    axi_slv_rd #(
        .AXI_ID_WIDTH   (4),
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (64),
        .AXI_LEN_WIDTH  (8),
        .AXI_SIZE_WIDTH (3),
        .AXI_BURST_WIDTH(2),
        .AXI_RESP_WIDTH (2),
        .AXI_USER_WIDTH (4),
        .AR_DEPTH       (4),
        .RD_LATENCY     (2),
        .ADDR_LIMIT     (32'h1000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .axi_slv_arid    (arid),
        .axi_slv_araddr  (araddr),
        .axi_slv_arlen   (arlen),
        .axi_slv_arsize  (arsize),
        .axi_slv_arburst (arburst),
        .axi_slv_aruser  (aruser),
        .axi_slv_arvalid (arvalid),
        .axi_slv_arready (arready),
        .axi_slv_rid     (rid),
        .axi_slv_rdata   (rdata),
        .axi_slv_rresp   (rresp),
        .axi_slv_ruser   (ruser),
        .axi_slv_rlast   (rlast),
        .axi_slv_rvalid  (rvalid),
        .axi_slv_rready  (rready)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] FIXED = 2'd0, INCR = 2'd1, WRAP = 2'd2, RSVD = 2'd3;
    localparam logic [1:0] OKAY = 2'd0, SLVERR = 2'd2, DECERR = 2'd3;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  user;
        logic        dc;     // data not checked
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    beat_t cb;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Record every R handshake; samples the values present at the next posedge.
    always @(negedge clk) begin
        if (!rst && rvalid && rready) begin
            cb.id   = rid;
            cb.data = rdata;
            cb.resp = rresp;
            cb.last = rlast;
            cb.user = ruser;
            cb.dc   = 1'b0;
            got_q.push_back(cb);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [3:0] user);
        logic hs;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; aruser = user;
        arvalid = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (arready) begin
                hs = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        if (!hs) check("ar_handshake_timeout", 64'(hs), 64'(1));
    endtask

    task automatic exp_beat(input logic [3:0] id, input logic [63:0] data, input logic [1:0] resp,
                            input logic last, input logic [3:0] user, input logic dc);
        beat_t e;
        e.id = id; e.data = data; e.resp = resp; e.last = last; e.user = user; e.dc = dc;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for the expected number of beats, then compares in order.
    task automatic check_beats(input string tag);
        int unsigned n;
        beat_t g;
        beat_t e;
        n = exp_q.size();
        for (int i = 0; i < 500 && got_q.size() < n; i++) @(negedge clk);
        repeat (6) @(negedge clk);
        check($sformatf("%s_count", tag), 64'(got_q.size()), 64'(n));
        for (int i = 0; i < int'(n); i++) begin
            if (i < got_q.size()) begin
                g = got_q[i];
                e = exp_q[i];
                if (!e.dc) check($sformatf("%s_b%0d_data", tag, i), g.data, e.data);
                check($sformatf("%s_b%0d_resp", tag, i), 64'(g.resp), 64'(e.resp));
                check($sformatf("%s_b%0d_last", tag, i), 64'(g.last), 64'(e.last));
                check($sformatf("%s_b%0d_id", tag, i), 64'(g.id), 64'(e.id));
                check($sformatf("%s_b%0d_user", tag, i), 64'(g.user), 64'(e.user));
            end
        end
        got_q.delete();
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        int unsigned acc;
        logic        hs;
        logic        found;

        rst = 1'b1; arvalid = 1'b0; rready = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; aruser = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_arready", 64'(arready), 64'(1));
        check("rst_rvalid",  64'(rvalid),  64'(0));
        check("rst_rlast",   64'(rlast),   64'(0));
        check("rst_rdata",   rdata,        64'(0));
        check("rst_rid",     64'(rid),     64'(0));
        check("rst_rresp",   64'(rresp),   64'(0));
        check("rst_ruser",   64'(ruser),   64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // INCR aligned, with latency measurement
        drive_ar(4'd1, 32'h10, 8'd3, 3'd2, INCR, 4'd5);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (rvalid) break;
        end
        check("incr_latency", 64'(n), 64'(5));
        exp_beat(4'd1, 64'h10, OKAY, 1'b0, 4'd5, 1'b0);
        exp_beat(4'd1, 64'h14, OKAY, 1'b0, 4'd5, 1'b0);
        exp_beat(4'd1, 64'h18, OKAY, 1'b0, 4'd5, 1'b0);
        exp_beat(4'd1, 64'h1C, OKAY, 1'b1, 4'd5, 1'b0);
        check_beats("incr");

        // INCR unaligned start, then reserved burst type (SLVERR, INCR addressing)
        drive_ar(4'd2, 32'h13, 8'd1, 3'd2, INCR, 4'd6);
        drive_ar(4'd3, 32'h50, 8'd1, 3'd2, RSVD, 4'd7);
        exp_beat(4'd2, 64'h13, OKAY,   1'b0, 4'd6, 1'b0);
        exp_beat(4'd2, 64'h14, OKAY,   1'b1, 4'd6, 1'b0);
        exp_beat(4'd3, 64'h50, SLVERR, 1'b0, 4'd7, 1'b0);
        exp_beat(4'd3, 64'h54, SLVERR, 1'b1, 4'd7, 1'b0);
        check_beats("unal_rsvd");

        // WRAP legal, WRAP with bad length, WRAP with unaligned start
        drive_ar(4'd4, 32'h24, 8'd3, 3'd2, WRAP, 4'd1);
        drive_ar(4'd5, 32'h24, 8'd2, 3'd2, WRAP, 4'd2);
        drive_ar(4'd6, 32'h26, 8'd3, 3'd2, WRAP, 4'd3);
        exp_beat(4'd4, 64'h24, OKAY, 1'b0, 4'd1, 1'b0);
        exp_beat(4'd4, 64'h28, OKAY, 1'b0, 4'd1, 1'b0);
        exp_beat(4'd4, 64'h2C, OKAY, 1'b0, 4'd1, 1'b0);
        exp_beat(4'd4, 64'h20, OKAY, 1'b1, 4'd1, 1'b0);
        exp_beat(4'd5, 64'h0, SLVERR, 1'b0, 4'd2, 1'b1);
        exp_beat(4'd5, 64'h0, SLVERR, 1'b0, 4'd2, 1'b1);
        exp_beat(4'd5, 64'h0, SLVERR, 1'b1, 4'd2, 1'b1);
        for (int k = 0; k < 4; k++) exp_beat(4'd6, 64'h0, SLVERR, (k == 3), 4'd3, 1'b1);
        check_beats("wrap");

        // FIXED
        drive_ar(4'd7, 32'h30, 8'd3, 3'd2, FIXED, 4'd4);
        for (int k = 0; k < 4; k++) exp_beat(4'd7, 64'h30, OKAY, (k == 3), 4'd4, 1'b0);
        check_beats("fixed");

        // DECERR boundary
        drive_ar(4'd8, 32'hFF8, 8'd3, 3'd2, INCR, 4'd9);
        exp_beat(4'd8, 64'hFF8,  OKAY,   1'b0, 4'd9, 1'b0);
        exp_beat(4'd8, 64'hFFC,  OKAY,   1'b0, 4'd9, 1'b0);
        exp_beat(4'd8, 64'h1000, DECERR, 1'b0, 4'd9, 1'b0);
        exp_beat(4'd8, 64'h1004, DECERR, 1'b1, 4'd9, 1'b0);
        check_beats("decerr");

        // Backpressure / FIFO full
        rready = 1'b0;
        acc = 0;
        arid = 4'd0; araddr = 32'h100; arlen = 8'd3; arsize = 3'd2; arburst = INCR; aruser = 4'd0;
        arvalid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            hs = arready;
            if (c >= 12) begin
                check($sformatf("bp_stall_rvalid_c%0d", c), 64'(rvalid), 64'(1));
                check($sformatf("bp_stall_rdata_c%0d", c), rdata, 64'h100);
            end
            @(posedge clk);
            #1;
            if (hs) begin
                acc++;
                arid = 4'(acc); aruser = 4'(acc); araddr = 32'h100 + 32'(acc) * 32'h40;
            end
        end
        arvalid = 1'b0;
        check("bp_accepted", 64'(acc), 64'(5));
        @(negedge clk);
        check("bp_arready_full", 64'(arready), 64'(0));
        @(posedge clk); #1;
        rready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (arready) begin
                found = 1'b1;
                break;
            end
        end
        check("bp_arready_reassert", 64'(found), 64'(1));
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) begin
                exp_beat(4'(i), 64'(32'h100 + 32'(i) * 32'h40 + 32'(k) * 32'h4), OKAY, (k == 3), 4'(i), 1'b0);
            end
        end
        check_beats("bp");

        // Reset mid-burst with two requests queued
        rready = 1'b0;
        drive_ar(4'd7, 32'h200, 8'd3, 3'd2, INCR, 4'd1);
        drive_ar(4'd8, 32'h240, 8'd3, 3'd2, INCR, 4'd1);
        drive_ar(4'd9, 32'h280, 8'd3, 3'd2, INCR, 4'd1);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rvalid) begin
                found = 1'b1;
                break;
            end
        end
        check("rstmid_first_valid", 64'(found), 64'(1));
        @(posedge clk); #1;
        rready = 1'b1;
        @(posedge clk);       // first beat handshakes here
        #3;
        rst = 1'b1;
        #1;
        check("rstmid_rvalid", 64'(rvalid), 64'(0));
        check("rstmid_arready", 64'(arready), 64'(1));
        check("rstmid_rlast", 64'(rlast), 64'(0));
        check("rstmid_beats_before", 64'(got_q.size()), 64'(1));
        if (got_q.size() > 0) check("rstmid_beat0_data", got_q[0].data, 64'h200);
        got_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("rstmid_no_stale", 64'(got_q.size()), 64'(0));
        check("rstmid_rvalid_idle", 64'(rvalid), 64'(0));
        @(posedge clk); #1;
        drive_ar(4'd3, 32'h40, 8'd1, 3'd2, INCR, 4'd2);
        exp_beat(4'd3, 64'h40, OKAY, 1'b0, 4'd2, 1'b0);
        exp_beat(4'd3, 64'h44, OKAY, 1'b1, 4'd2, 1'b0);
        check_beats("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
